// File: rtl/btype_enc_pkg.sv
// btype_enc_pkg: shared RISC-V branch constants (opcode, funct3 codes, field widths) and FIFO entry type.
package btype_enc_pkg;
   localparam int XLEN = 32;
   localparam int REG_W = 5;
   localparam int F3_W = 3;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [F3_W-1:0] F3_BEQ = 3'b000;
   localparam logic [F3_W-1:0] F3_BNE = 3'b001;
   localparam logic [F3_W-1:0] F3_BLT = 3'b100;
   localparam logic [F3_W-1:0] F3_BGE = 3'b101;
   localparam logic [F3_W-1:0] F3_BLTU = 3'b110;
   localparam logic [F3_W-1:0] F3_BGEU = 3'b111;
   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic err;
   } entry_t;
   function automatic logic f3_legal(input logic [F3_W-1:0] f);
      return f inside {F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU};
   endfunction
endpackage

// File: rtl/btype_enc_pack.sv
// btype_pack: combinational B-type field packing; offset bits outside [12:1] are dropped.
module btype_pack
   import btype_enc_pkg::*;
(
   input  logic [XLEN-1:0]  offset,
   input  logic [REG_W-1:0] rs1,
   input  logic [REG_W-1:0] rs2,
   input  logic [F3_W-1:0]  funct3,
   output logic [XLEN-1:0]  instr
);
   logic unused_off;
   assign unused_off = ^{offset[31:13], offset[0]};
   assign instr = {offset[12], offset[10:5], rs2, rs1, funct3, offset[4:1], offset[11], OPC_BRANCH};
endmodule

// File: rtl/btype_enc.sv
// btype_enc: encodes branch requests into B-type instructions behind a 2-entry output FIFO.
// Define BTYPE_ENC_CHECK_EN to flag bad offsets/funct3 and count erroring requests.
module btype_enc
   import btype_enc_pkg::*;
#(
   parameter int ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [XLEN-1:0]      in_offset,
   input  logic [REG_W-1:0]     in_rs1,
   input  logic [REG_W-1:0]     in_rs2,
   input  logic [F3_W-1:0]      in_funct3,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [XLEN-1:0]      out_instr,
   output logic                 out_err,
   output logic [ERR_CNT_W-1:0] err_count
);
   logic [1:0] count;
   entry_t e0, e1, nxt;
   logic push, pop, err;
   logic [XLEN-1:0] instr;
   btype_pack u_pack (
      .offset(in_offset),
      .rs1(in_rs1),
      .rs2(in_rs2),
      .funct3(in_funct3),
      .instr(instr)
   );
`ifdef BTYPE_ENC_CHECK_EN
   // reachable range is -4096..+4094: bits 31:12 must be a pure sign extension
   assign err = in_offset[0] | (in_offset[31:12] != {20{in_offset[31]}}) | !f3_legal(in_funct3);
`else
   assign err = 1'b0;
`endif
   assign in_ready = count != 2'd2;
   assign out_valid = count != 2'd0;
   assign push = in_valid & in_ready;
   assign pop = out_valid & out_ready;
   assign nxt = '{instr: instr, err: err};
   assign out_instr = e0.instr;
   assign out_err = e0.err;
   // e0 is the head; e1 only ever holds the second entry
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         count <= 2'd0;
         e0 <= '0;
         e1 <= '0;
      end else begin
         count <= count + {1'b0, push} - {1'b0, pop};
         if (pop) e0 <= (push && count == 2'd1) ? nxt : e1;
         else if (push && count == 2'd0) e0 <= nxt;
         if (push && !pop && count == 2'd1) e1 <= nxt;
      end
`ifdef BTYPE_ENC_CHECK_EN
   logic [ERR_CNT_W-1:0] cnt;
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) cnt <= '0;
      else if (push && err && cnt != '1) cnt <= cnt + 1'b1;
   assign err_count = cnt;
`else
   assign err_count = '0;
`endif
endmodule

// File: tb/tb_btype_enc.sv
// tb_btype_enc: directed plus random stimulus against a queue-based reference model of btype_enc.
module tb_btype_enc;
   logic clk = 1'b0, resetn = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic [31:0] in_offset = '0;
   logic [4:0] in_rs1 = '0, in_rs2 = '0;
   logic [2:0] in_funct3 = '0;
   logic in_ready, out_valid, out_err;
   logic [31:0] out_instr;
   logic [7:0] err_count;
   int checks = 0, errors = 0, mec = 0;
   typedef struct {logic [31:0] instr; logic err;} exp_t;
   exp_t mq[$];
`ifdef BTYPE_ENC_CHECK_EN
   localparam bit chk_en = 1'b1;
`else
   localparam bit chk_en = 1'b0;
`endif

   btype_enc dut (
      .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
      .in_offset(in_offset), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
      .out_err(out_err), .err_count(err_count)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] enc(input logic [31:0] o, input int r1, input int r2, input int f3);
      return (((o >> 12) & 1) << 31) | (((o >> 5) & 63) << 25) | (r2 << 20) | (r1 << 15)
           | (f3 << 12) | (((o >> 1) & 15) << 8) | (((o >> 11) & 1) << 7) | 32'h63;
   endfunction

   function automatic bit bad(input logic [31:0] o, input int f3);
      int so = $signed(o);
      return chk_en && (so < -4096 || so > 4094 || o % 2 != 0 || f3 == 2 || f3 == 3);
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   // called at a negedge: drive, check pre-edge state, advance model across the posedge
   task automatic cyc(input bit v, input logic [31:0] o, input logic [4:0] a, input logic [4:0] b,
                      input logic [2:0] f, input bit r);
      bit push, pop;
      exp_t e;
      in_valid = v; in_offset = o; in_rs1 = a; in_rs2 = b; in_funct3 = f; out_ready = r;
      #1;
      chk("in_ready", {31'b0, in_ready}, {31'b0, mq.size() < 2});
      chk("out_valid", {31'b0, out_valid}, {31'b0, mq.size() > 0});
      if (mq.size() > 0) begin
         chk("out_instr", out_instr, mq[0].instr);
         chk("out_err", {31'b0, out_err}, {31'b0, mq[0].err});
      end
      chk("err_count", {24'b0, err_count}, mec);
      push = v && mq.size() < 2;
      pop = r && mq.size() > 0;
      @(posedge clk);
      if (pop) void'(mq.pop_front());
      if (push) begin
         e.instr = enc(o, a, b, f);
         e.err = bad(o, f);
         mq.push_back(e);
         if (e.err && mec < 255) mec++;
      end
      @(negedge clk);
   endtask

   initial begin
      @(negedge clk);
      #1;
      chk("rst_out_valid", {31'b0, out_valid}, 0);
      chk("rst_out_instr", out_instr, 0);
      chk("rst_err_count", {24'b0, err_count}, 0);
      @(negedge clk);
      resetn = 1'b1;
      cyc(0, 0, 0, 0, 0, 1);
      cyc(1, 32'd8, 1, 2, 3'b000, 1);
      chk("vec_pos8", out_instr, 32'h00208463);
      cyc(1, 32'hFFFF_FFFC, 0, 0, 3'b001, 1);
      chk("vec_neg4", out_instr, 32'hFE001EE3);
      cyc(1, 32'd4096, 0, 0, 3'b000, 1);
      chk("vec_4096", out_instr, 32'h80000063);
      chk("vec_4096_err", {31'b0, out_err}, {31'b0, chk_en});
      cyc(0, 0, 0, 0, 0, 1);
      chk("vec_4096_cnt", {24'b0, err_count}, {31'b0, chk_en});
      cyc(1, 32'd16, 3, 4, 3'b100, 0);
      cyc(1, 32'd32, 5, 6, 3'b101, 0);
      cyc(1, 32'd64, 7, 8, 3'b110, 0);
      chk("full_in_ready", {31'b0, in_ready}, 0);
      cyc(1, 32'd64, 7, 8, 3'b110, 1);
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 200; i++)
         cyc($urandom_range(0, 3) != 0,
             $urandom_range(0, 3) == 0 ? $urandom : 32'($urandom_range(0, 8191)) - 32'd4096,
             5'($urandom), 5'($urandom), 3'($urandom), $urandom_range(0, 3) != 0);
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 1);
      cyc(1, 32'd100, 9, 10, 3'b000, 0);
      cyc(1, 32'd200, 11, 12, 3'b001, 0);
      #2 resetn = 1'b0;
      #1;
      chk("mid_rst_valid", {31'b0, out_valid}, 0);
      chk("mid_rst_instr", out_instr, 0);
      chk("mid_rst_cnt", {24'b0, err_count}, 0);
      mq.delete();
      mec = 0;
      @(negedge clk);
      resetn = 1'b1;
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 300; i++) cyc(1, 32'd3, 0, 0, 3'b000, 1);
      cyc(0, 0, 0, 0, 0, 1);
      chk("sat_cnt", {24'b0, err_count}, chk_en ? 32'd255 : 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
